seq_det_prog: RTL and testbench

//  Programmable, parametrised Moore serial sequence detector. Successor to the fixed 1010 detectors.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_det_cmp.sv | 23 ++
 rtl/seq_det_prog.sv | 138 +++++++++++++
 tb/tb_seq_det_prog.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the programmable serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ARMED = 2'd1,
        S_HIT   = 2'd2
    } state_e;

    localparam int unsigned DEF_PATTERN = 32'b1010;
    localparam int unsigned DEF_LEN     = 4;
    localparam bit          DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_det_cmp.sv
// Masked compare of the next history word against the pattern; only the low len bits count.
module seq_det_cmp #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] i_hist,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_eq_c
);
    import seq_det_pkg::*;

    logic [MAX_LEN-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < i_len);
        end
        o_eq_c = (((i_hist ^ i_pattern) & w_mask) == '0);
    end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable Moore serial sequence detector with runtime pattern/length/overlap.
// Optional saturating match counter on o_match_cnt when MATCH_CNT_EN is defined.
module seq_det_prog #(
    parameter int unsigned          MAX_LEN     = 8,
    parameter int unsigned          LEN_W       = $clog2(MAX_LEN + 1),
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
    parameter int unsigned          DEF_LEN     = seq_det_pkg::DEF_LEN,
    parameter bit                   DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP
`ifdef MATCH_CNT_EN
    ,
    parameter int unsigned          CNT_W       = 16
`endif
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_cfg_load,
    input  logic [MAX_LEN-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0]   i_cfg_len,
    input  logic               i_cfg_overlap,
    input  logic               i_in_valid,
    input  logic               i_in,
    output logic               o_out,
    output logic               o_cfg_err
`ifdef MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   o_match_cnt
`endif
);
    import seq_det_pkg::*;

    localparam int unsigned LW1 = LEN_W + 1;

    state_e             r_state, w_state_next;
    logic [MAX_LEN-1:0] r_pattern, w_pattern_next;
    logic [LEN_W-1:0]   r_len, w_len_next;
    logic               r_overlap, w_overlap_next;
    logic [MAX_LEN-2:0] r_hist, w_hist_keep;
    logic [LEN_W-1:0]   r_fill, w_fill_next, w_fill_inc;
    logic               r_out, r_cfg_err, w_cfg_err_next;
    logic [MAX_LEN-1:0] w_hist_next;
    logic               w_beat, w_eq, w_full, w_match, w_len_ok;
`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
`endif

    assign w_beat      = i_en & i_in_valid & ~i_cfg_load;
    assign w_hist_next = {r_hist, i_in};
    assign w_fill_inc  = (r_fill < r_len) ? r_fill + LEN_W'(1) : r_fill;
    assign w_full      = (LW1'(r_fill) + LW1'(1)) >= LW1'(r_len);
    assign w_match     = w_full & w_eq;
    assign w_len_ok    = (i_cfg_len != '0) && (i_cfg_len <= LEN_W'(MAX_LEN));

    seq_det_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .i_hist    (w_hist_next),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .o_eq_c    (w_eq)
    );

    // Next-state: cfg_load outranks a same-cycle bit; a rejected load is a plain non-beat cycle.
    always_comb begin
        w_state_next   = r_state;
        w_pattern_next = r_pattern;
        w_len_next     = r_len;
        w_overlap_next = r_overlap;
        w_hist_keep    = r_hist;
        w_fill_next    = r_fill;
        w_cfg_err_next = 1'b0;
`ifdef MATCH_CNT_EN
        w_cnt_next     = r_cnt;
`endif
        if (i_cfg_load && w_len_ok) begin
            w_pattern_next = i_cfg_pattern;
            w_len_next     = i_cfg_len;
            w_overlap_next = i_cfg_overlap;
            w_hist_keep    = '0;
            w_fill_next    = '0;
            w_state_next   = S_FILL;
`ifdef MATCH_CNT_EN
            w_cnt_next     = '0;
`endif
        end else if (w_beat) begin
            w_hist_keep = w_hist_next[MAX_LEN-2:0];
            if (w_match) begin
                w_state_next = S_HIT;
                w_fill_next  = r_overlap ? w_fill_inc : '0;
`ifdef MATCH_CNT_EN
                if (r_cnt != '1) w_cnt_next = r_cnt + CNT_W'(1);
`endif
            end else begin
                w_fill_next  = w_fill_inc;
                w_state_next = (w_fill_inc == r_len) ? S_ARMED : S_FILL;
            end
        end else if (r_state == S_HIT) begin
            w_state_next = r_overlap ? S_ARMED : S_FILL;
        end
        if (i_cfg_load && !w_len_ok) w_cfg_err_next = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_FILL;
            r_pattern <= DEF_PATTERN;
            r_len     <= LEN_W'(DEF_LEN);
            r_overlap <= DEF_OVERLAP;
            r_hist    <= '0;
            r_fill    <= '0;
            r_out     <= 1'b0;
            r_cfg_err <= 1'b0;
`ifdef MATCH_CNT_EN
            r_cnt     <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_pattern <= w_pattern_next;
            r_len     <= w_len_next;
            r_overlap <= w_overlap_next;
            r_hist    <= w_hist_keep;
            r_fill    <= w_fill_next;
            r_out     <= (w_state_next == S_HIT);
            r_cfg_err <= w_cfg_err_next;
`ifdef MATCH_CNT_EN
            r_cnt     <= w_cnt_next;
`endif
        end
    end

    assign o_out     = r_out;
    assign o_cfg_err = r_cfg_err;
`ifdef MATCH_CNT_EN
    assign o_match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed self-checking bench for seq_det_prog (MAX_LEN=8; CNT_W=4 when MATCH_CNT_EN is defined).
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       out;
    logic       cfg_err;
`ifdef MATCH_CNT_EN
    logic [3:0] match_cnt;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_det_prog #(
        .MAX_LEN (8)
`ifdef MATCH_CNT_EN
        , .CNT_W (4)
`endif
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_cfg_load    (cfg_load),
        .i_cfg_pattern (cfg_pattern),
        .i_cfg_len     (cfg_len),
        .i_cfg_overlap (cfg_overlap),
        .i_in_valid    (in_valid),
        .i_in          (in_bit),
        .o_out         (out),
        .o_cfg_err     (cfg_err)
`ifdef MATCH_CNT_EN
        , .o_match_cnt (match_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cfg_load = 1'b0;
        tick();
    endtask

    task automatic send(input logic b);
        en       = 1'b1;
        cfg_load = 1'b0;
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        in_valid    = 1'b0;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (out !== 1'b0) begin bad++; $display("FAIL reset_out: got %b want 0", out); end
        total++;
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
`ifdef MATCH_CNT_EN
        total++;
        if (match_cnt !== 4'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0", match_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_default_overlap();
        logic [7:0] s;
        logic [7:0] e;
        s = 8'b10101010;
        e = 8'b00010101;
        for (int i = 0; i < 8; i++) begin
            send(s[7-i]);
            total++;
            if (out !== e[7-i]) begin bad++; $display("FAIL default_ovl bit%0d: got %b want %b", i + 1, out, e[7-i]); end
        end
        idle();
        total++;
        if (out !== 1'b0) begin bad++; $display("FAIL default_ovl idle: got %b want 0", out); end
    endtask

    task automatic test_nonoverlap();
        logic [7:0] s;
        logic [7:0] e;
        s = 8'b10101010;
        e = 8'b00010001;
        load(8'h0A, 4'd4, 1'b0);
        total++;
        if (out !== 1'b0 || cfg_err !== 1'b0) begin
            bad++; $display("FAIL nonovl_load: out=%b err=%b want 0 0", out, cfg_err);
        end
        for (int i = 0; i < 8; i++) begin
            send(s[7-i]);
            total++;
            if (out !== e[7-i]) begin bad++; $display("FAIL nonovl bit%0d: got %b want %b", i + 1, out, e[7-i]); end
        end
`ifdef MATCH_CNT_EN
        total++;
        if (match_cnt !== 4'd2) begin bad++; $display("FAIL nonovl_cnt: got %0d want 2", match_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        logic e;
        load(8'hFF, 4'd8, 1'b1);
        for (int i = 0; i < 9; i++) begin
            send(1'b1);
            e = (i >= 7);
            total++;
            if (out !== e) begin bad++; $display("FAIL b2b bit%0d: got %b want %b", i + 1, out, e); end
        end
    endtask

    task automatic test_cfg_err();
        load(8'h0A, 4'd4, 1'b1);
        send(1'b1);
        send(1'b0);
        send(1'b1);
        load(8'hFF, 4'd0, 1'b0);
        total++;
        if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_len0: got %b want 1", cfg_err); end
        idle();
        total++;
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_pulse: got %b want 0", cfg_err); end
        send(1'b0);
        total++;
        if (out !== 1'b1) begin bad++; $display("FAIL cfg_err_keep_hist: got %b want 1", out); end
        load(8'hFF, 4'd9, 1'b0);
        total++;
        if (cfg_err !== 1'b1 || out !== 1'b0) begin
            bad++; $display("FAIL cfg_err_len9: err=%b out=%b want 1 0", cfg_err, out);
        end
        send(1'b1);
        send(1'b0);
        total++;
        if (out !== 1'b1) begin bad++; $display("FAIL cfg_err_keep_cfg: got %b want 1", out); end
    endtask

    task automatic test_load_drops_beat();
        logic [4:0] s;
        logic [4:0] e;
        s = 5'b01010;
        e = 5'b00001;
        en          = 1'b1;
        cfg_load    = 1'b1;
        cfg_pattern = 8'h0A;
        cfg_len     = 4'd4;
        cfg_overlap = 1'b1;
        in_valid    = 1'b1;
        in_bit      = 1'b1;
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(s[4-i]);
            total++;
            if (out !== e[4-i]) begin bad++; $display("FAIL drop bit%0d: got %b want %b", i + 1, out, e[4-i]); end
        end
    endtask

    task automatic test_gaps();
        load(8'h0A, 4'd4, 1'b1);
        send(1'b1);
        idle();
        total++;
        if (out !== 1'b0) begin bad++; $display("FAIL gap1: got %b want 0", out); end
        send(1'b0);
        idle();
        idle();
        send(1'b1);
        total++;
        if (out !== 1'b0) begin bad++; $display("FAIL gap_bit3: got %b want 0", out); end
        en       = 1'b0;
        in_valid = 1'b1;
        in_bit   = 1'b0;
        tick();
        in_valid = 1'b0;
        total++;
        if (out !== 1'b0) begin bad++; $display("FAIL gap_en0: got %b want 0", out); end
        idle();
        idle();
        send(1'b0);
        total++;
        if (out !== 1'b1) begin bad++; $display("FAIL gap_match: got %b want 1", out); end
        idle();
        total++;
        if (out !== 1'b0) begin bad++; $display("FAIL gap_after: got %b want 0", out); end
    endtask

    task automatic test_len1();
        logic [3:0] s;
        s = 4'b1101;
        load(8'h01, 4'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(s[3-i]);
            total++;
            if (out !== s[3-i]) begin bad++; $display("FAIL len1 bit%0d: got %b want %b", i + 1, out, s[3-i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] s;
        s = 4'b1010;
        load(8'h0A, 4'd4, 1'b1);
        send(1'b1);
        send(1'b0);
        send(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out !== 1'b0) begin bad++; $display("FAIL rst_mid_out: got %b want 0", out); end
        send(1'b0);
        total++;
        if (out !== 1'b0) begin bad++; $display("FAIL rst_mid_nomatch: got %b want 0", out); end
        load(8'h01, 4'd1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(s[3-i]);
        end
        total++;
        if (out !== 1'b1) begin bad++; $display("FAIL rst_defaults: got %b want 1", out); end
    endtask

`ifdef MATCH_CNT_EN
    task automatic test_saturate();
        load(8'h01, 4'd1, 1'b1);
        total++;
        if (match_cnt !== 4'h0) begin bad++; $display("FAIL sat_clear: got %h want 0", match_cnt); end
        for (int i = 0; i < 14; i++) send(1'b1);
        total++;
        if (match_cnt !== 4'hE) begin bad++; $display("FAIL sat_mid: got %h want e", match_cnt); end
        for (int i = 0; i < 3; i++) send(1'b1);
        total++;
        if (match_cnt !== 4'hF || out !== 1'b1) begin
            bad++; $display("FAIL sat_end: cnt=%h out=%b want f 1", match_cnt, out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_overlap();
        test_nonoverlap();
        test_back_to_back();
        test_cfg_err();
        test_load_drops_beat();
        test_gaps();
        test_len1();
        test_reset_mid();
`ifdef MATCH_CNT_EN
        test_saturate();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
